// File: rtl/wb_pkg.sv
// Shared writeback definitions: load-width codes, default select map and
// the occupancy states of the writeback skid buffer.
package wb_pkg;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    // Select codes for the default 8-source configuration
    localparam int ALUOUT = 0;
    localparam int MDR    = 1;
    localparam int LUI    = 2;
    localparam int LO     = 3;
    localparam int HI     = 4;
    localparam int SHIFT  = 5;
    localparam int CONST  = 6;
    localparam int LT     = 7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } occ_state_e;

endpackage

// File: rtl/load_extract.sv
// Byte/halfword/word extraction from a 32-bit word with sign or zero
// extension; shared by the load writeback path and the store path.
module load_extract
    import wb_pkg::*;
(
    input  logic [31:0] din,
    input  logic [1:0]  ld_mode,
    input  logic        ld_sign,
    input  logic [1:0]  ld_off,
    output logic [31:0] dout
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = din[8*ld_off +: 8];
        // Halfwords are aligned; the low offset bit does not move the window
        half_v = ld_off[1] ? din[31:16] : din[15:0];
        dout   = din;
        case (ld_mode)
            LD_BYTE: dout = {{24{ld_sign & byte_v[7]}}, byte_v};
            LD_HALF: dout = {{16{ld_sign & half_v[15]}}, half_v};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/wb_data_select.sv
// Register-file write-data source select with load extraction, registered
// through a 2-entry skid buffer so writeback can be stalled losslessly.
module wb_data_select
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 8,
    parameter int SEL_W     = 4,
    parameter int CONST_IDX = CONST,
    parameter int CONST_VAL = 227,
    parameter int MDR_IDX   = MDR,
    parameter int LT_IDX    = LT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [1:0]              ld_mode_i,
    input  logic                    ld_sign_i,
    input  logic [1:0]              ld_off_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_err_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    logic [DATA_W-1:0] slice;
    logic [31:0]       ext32;
    logic [DATA_W-1:0] mdr_val;
    logic [DATA_W-1:0] sel_data;
    logic              sel_err;
    logic              accept;

    occ_state_e        state_q, state_n;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              main_err_q, skid_err_q;
    logic              in_ready_q;
    logic              main_ld, main_from_skid, skid_ld;

    assign accept = in_valid_i && in_ready_q;

    always_comb begin
        slice = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(sel_i) == k) slice = src_i[k*DATA_W +: DATA_W];
        end
    end

    load_extract u_extract (
        .din     (slice[31:0]),
        .ld_mode (ld_mode_i),
        .ld_sign (ld_sign_i),
        .ld_off  (ld_off_i),
        .dout    (ext32)
    );

    // Wider datapaths extend the 32-bit load result following ld_sign
    generate
        if (DATA_W > 32) begin : g_wide
            assign mdr_val = {{(DATA_W-32){ld_sign_i & ext32[31]}}, ext32};
        end else begin : g_narrow
            assign mdr_val = ext32;
        end
    endgenerate

    always_comb begin
        sel_data = slice;
        sel_err  = 1'b0;
        if (int'(sel_i) >= N_SRC) begin
            sel_data = '0;
            sel_err  = 1'b1;
        end else if (int'(sel_i) == CONST_IDX) begin
            sel_data = DATA_W'(CONST_VAL);
        end else if (int'(sel_i) == LT_IDX) begin
            sel_data = {{(DATA_W-1){1'b0}}, slice[0]};
        end else if (int'(sel_i) == MDR_IDX) begin
            sel_data = mdr_val;
        end
    end

    always_comb begin
        state_n        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_n = ST_FULL1;
                    main_ld = 1'b1;
                end
            end
            ST_FULL1: begin
                if (accept && out_ready_i) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    state_n = ST_FULL2;
                    skid_ld = 1'b1;
                end else if (out_ready_i) begin
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL2: begin
                if (out_ready_i) begin
                    state_n        = ST_FULL1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            if (main_ld) begin
                main_data_q <= sel_data;
                main_err_q  <= sel_err;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (skid_ld) begin
                skid_data_q <= sel_data;
                skid_err_q  <= sel_err;
            end
            // Ready is low exactly when the skid entry will be occupied
            in_ready_q <= (state_n != ST_FULL2);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_data_q;
    assign out_err_o   = main_err_q;

endmodule

// File: doc/wb_data_select.md
Name: wb_data_select

Overview:
- Parametrised, registered successor to the 8:1 write-data-source mux in the multicycle datapath.
- Selects one of N_SRC sources for register-file write data.
- For the memory-data source, extracts a byte or halfword with sign or zero extension.
- Result is held in a 2-entry skid buffer with valid/ready handshakes on both sides, so the control unit can stall writeback without losing data.

Parameters:
- DATA_W, 32, data width; must be 32 or 64.
- N_SRC, 8, number of source slices; range 2..16.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_SRC.
- CONST_IDX, 6, select code that returns CONST_VAL; the slice at this index is ignored.
- CONST_VAL, 227, constant returned for CONST_IDX, zero-extended to DATA_W.
- MDR_IDX, 1, select code whose slice undergoes load extraction.
- LT_IDX, 7, select code whose slice bit 0 is zero-extended; upper bits are ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_i  in  N_SRC*DATA_W  flattened sources; slice k is bits [k*DATA_W +: DATA_W].
- sel_i  in  SEL_W  source select.
- ld_mode_i  in  2  load width: 00 word, 01 half, 10 byte, 11 treated as word.
- ld_sign_i  in  1  1 = sign-extend, 0 = zero-extend.
- ld_off_i  in  2  byte offset within the word.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- out_data_o  out  DATA_W  selected write data.
- out_err_o  out  1  sel_i was >= N_SRC for this item.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  consumer ready.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid_o=0, out_data_o=0, out_err_o=0, in_ready_o=1.
  - Both buffer entries are cleared.
  - Reset mid-transfer discards all held items.
- Selection (combinational, evaluated on the accept cycle only):
  - sel_i==CONST_IDX gives CONST_VAL.
  - sel_i==LT_IDX gives {0, slice[0]}.
  - sel_i==MDR_IDX gives the extracted value (below).
  - Any other sel_i < N_SRC gives the slice unchanged.
  - sel_i >= N_SRC gives 0 with err=1.
  - Priority when codes coincide: CONST_IDX > LT_IDX > MDR_IDX.
- Extraction (applies to the low 32 bits; a 64-bit build sign- or zero-extends the result to DATA_W):
  - Byte: bits [8*off +: 8].
  - Half: bits [16*off[1] +: 16]; off[0] is ignored.
  - Word: the slice unchanged.
  - Extension follows ld_sign_i.
- Latency: an accepted item appears on out_data_o in the next cycle, provided the output entry is free or draining.
- Buffer entries are MAIN, which drives the outputs, and SKID.
- in_ready_o is registered and equals !skid_valid.
- State machine by occupancy:
  - EMPTY: accept -> FULL1.
  - FULL1:
    - accept && out_ready_i -> FULL1; MAIN is replaced.
    - accept && !out_ready_i -> FULL2; new item goes to SKID.
    - no accept && out_ready_i -> EMPTY.
  - FULL2: in_ready_o=0.
    - out_ready_i -> FULL1; SKID moves to MAIN.
    - otherwise hold.
- Order is strict FIFO; no item is dropped or duplicated.
- While out_valid_o && !out_ready_i, out_data_o and out_err_o are stable.
- Simultaneous accept and drain in FULL1 sustains 1 item/cycle.
- in_valid_i while in_ready_o=0 has no effect; the sender must hold its inputs.
- Outputs in EMPTY: out_valid_o=0; out_data_o holds its last value and is don't-care.

Decomposition:
- Shared package wb_pkg holds:
  - load-mode constants LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10;
  - default select codes for the 8-source configuration: ALUOUT=0, MDR=1, LUI=2, LO=3, HI=4, SHIFT=5, CONST=6, LT=7.
- One sub-module: load_extract, combinational, 32-bit in/out; ports ld_mode, ld_sign, ld_off. Reused by the store path later.
- The skid buffer stays inline.

Test Plan:
- Reset release, then sel=6 with in_valid for 1 cycle and out_ready=1 -> next cycle out_valid=1, out_data=32'd227, out_err=0.
- sel=1, MDR slice=32'h80F1_2384, byte off=3, sign=1 -> out_data=32'hFFFF_FF80. Same item with sign=0 -> 32'h0000_0080. Half off=2, sign=1 -> 32'hFFFF_80F1.
- sel=7, slice=32'hFFFF_FFFE -> 0. Slice=32'h0000_0003 -> 1.
- Stream 3 items A, B, C on sel=0 with out_ready=0:
  - A in MAIN, B in SKID, in_ready=0 after B; C is held by the sender.
  - Raise out_ready -> A, B, C emerge in order over 3 cycles with no bubbles after the first.
- N_SRC=5 build, sel=9 -> out_data=0, out_err=1; the next item with sel=2 has out_err=0.
- Assert reset while in FULL2 -> out_valid=0 and in_ready=1 immediately; after release, the first accepted item is the first output.
